// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the ram_dp_clear block:
//   - ram_state_e : zeroing sequencer states (IDLE, CLEAR)
//   - RDW_OLD / RDW_NEW : read-during-write policy selectors
//   - lanes()  : number of write-mask lanes in a word
//   - addr_w() : address width for a given depth (at least 1 bit)
// ----------------------------------------------------------------------------
package ram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_e;

  localparam int unsigned RDW_OLD = 32'd0;
  localparam int unsigned RDW_NEW = 32'd1;

  function automatic int unsigned lanes(input int unsigned size,
                                        input int unsigned lane_w);
    return size / lane_w;
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth);
    if (depth > 32'd1) begin
      return $clog2(depth);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ----------------------------------------------------------------------------
// ram_clear_seq
// Zeroing sequencer for ram_dp_clear. Leaves reset in CLEAR and walks the
// pointer from 0 to DEPTH-1, one entry per cycle, then parks in IDLE. A clear
// request in IDLE starts a fresh sweep; a request during a sweep is ignored.
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset (restarts the sweep)
//   clear_i      : request a new sweep (honoured only in IDLE)
//   busy_o       : registered, high while a sweep is in progress
//   sweep_we_o   : array write strobe for the sweep (zero data)
//   sweep_addr_o : entry being zeroed this cycle
// ----------------------------------------------------------------------------
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = 32'd32,
  parameter int unsigned AW    = addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  output logic          busy_o,
  output logic          sweep_we_o,
  output logic [AW-1:0] sweep_addr_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 32'd1);

  ram_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          busy_q, busy_d;

  // Next-state and pointer logic; the pointer stops at DEPTH-1 and never
  // wraps into a second sweep.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          state_d = CLEAR;
          ptr_d   = ptr_q + AW'(1);
        end
      end
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else begin
          state_d = IDLE;
          ptr_d   = ptr_q;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  // State, pointer and busy registers; reset starts a sweep from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // busy_q tracks state_q == CLEAR exactly, so it doubles as the sweep strobe.
  assign busy_o       = busy_q;
  assign sweep_we_o   = busy_q;
  assign sweep_addr_o = ptr_q;

endmodule

// File: rtl/ram_dp_clear.sv
// ----------------------------------------------------------------------------
// ram_dp_clear
// Simple dual-port synchronous RAM (one write port, one read port) with
// per-lane write masking, selectable same-address read-during-write policy
// and a built-in zeroing sweep after reset or on request.
//
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   clear             : pulse to start a zeroing sweep (ignored while busy)
//   busy              : high while the sweep runs; user traffic is ignored
//   wr_en/wr_address  : write request and address
//   wr_data/wr_mask   : write data and per-lane enables (LANE_W bits each)
//   rd_en/rd_address  : read request and address
//   read_data         : registered read data (1-cycle latency, holds)
//   rd_valid          : read_data was updated on the last edge
//
// Parameters: SIZE (word bits), DEPTH (entries, any value), LANE_W (lane
// bits, divides SIZE), RDW_MODE (RDW_OLD or RDW_NEW).
// ----------------------------------------------------------------------------
module ram_dp_clear
  import ram_pkg::*;
#(
  parameter int unsigned SIZE     = 32'd8,
  parameter int unsigned DEPTH    = 32'd32,
  parameter int unsigned LANE_W   = 32'd8,
  parameter int unsigned RDW_MODE = RDW_OLD
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  output logic                            busy,
  input  logic                            wr_en,
  input  logic [$clog2(DEPTH)-1:0]        wr_address,
  input  logic [SIZE-1:0]                 wr_data,
  input  logic [lanes(SIZE, LANE_W)-1:0]  wr_mask,
  input  logic                            rd_en,
  input  logic [$clog2(DEPTH)-1:0]        rd_address,
  output logic [SIZE-1:0]                 read_data,
  output logic                            rd_valid
);

  localparam int unsigned LANES = lanes(SIZE, LANE_W);
  localparam int unsigned AW    = $clog2(DEPTH);

  // Sequencer interface
  logic          busy_s;
  logic          sweep_we_s;
  logic [AW-1:0] sweep_addr_s;

  // Request qualification
  logic wr_in_range_s;
  logic rd_in_range_s;
  logic user_wr_s;
  logic user_rd_s;
  logic rdw_hit_s;

  // Storage and its single write port
  logic [SIZE-1:0]  mem_q [DEPTH];
  logic             arr_we_s;
  logic [AW-1:0]    arr_addr_s;
  logic [SIZE-1:0]  arr_wdata_s;
  logic [LANES-1:0] arr_lane_we_s;

  // Read path
  logic [SIZE-1:0] old_word_s;
  logic [SIZE-1:0] merged_word_s;
  logic [SIZE-1:0] rd_word_s;
  logic [SIZE-1:0] read_data_q, read_data_d;
  logic            rd_valid_q, rd_valid_d;

  ram_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear),
    .busy_o       (busy_s),
    .sweep_we_o   (sweep_we_s),
    .sweep_addr_o (sweep_addr_s)
  );

  // Addresses only go out of range when DEPTH is not a power of two.
  if ((32'd1 << AW) == DEPTH) begin : g_pow2
    assign wr_in_range_s = 1'b1;
    assign rd_in_range_s = 1'b1;
  end else begin : g_npow2
    assign wr_in_range_s = (wr_address < AW'(DEPTH));
    assign rd_in_range_s = (rd_address < AW'(DEPTH));
  end

  // Qualify user requests; an all-zero mask is treated as no write.
  always_comb begin
    user_wr_s = ~busy_s & wr_en & wr_in_range_s & (|wr_mask);
    user_rd_s = ~busy_s & rd_en;
    rdw_hit_s = user_wr_s & user_rd_s & (wr_address == rd_address);
  end

  // Write-port mux: the sweep owns the port while busy, else the user write.
  always_comb begin
    arr_we_s      = 1'b0;
    arr_addr_s    = '0;
    arr_wdata_s   = '0;
    arr_lane_we_s = '0;
    if (sweep_we_s) begin
      arr_we_s      = 1'b1;
      arr_addr_s    = sweep_addr_s;
      arr_wdata_s   = '0;
      arr_lane_we_s = '1;
    end else if (user_wr_s) begin
      arr_we_s      = 1'b1;
      arr_addr_s    = wr_address;
      arr_wdata_s   = wr_data;
      arr_lane_we_s = wr_mask;
    end else begin
      arr_we_s      = 1'b0;
    end
  end

  // Storage array: lane-granular writes, no reset (the sweep zeroes it).
  always_ff @(posedge clk) begin
    if (arr_we_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (arr_lane_we_s[i]) begin
          mem_q[arr_addr_s][i*LANE_W +: LANE_W] <= arr_wdata_s[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read word: out-of-range reads return zero; in write-through mode a
  // same-address write is merged lane by lane into the returned word.
  always_comb begin
    old_word_s = '0;
    if (rd_in_range_s) begin
      old_word_s = mem_q[rd_address];
    end else begin
      old_word_s = '0;
    end
    merged_word_s = old_word_s;
    for (int i = 0; i < LANES; i++) begin
      if (wr_mask[i]) begin
        merged_word_s[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
      end else begin
        merged_word_s[i*LANE_W +: LANE_W] = old_word_s[i*LANE_W +: LANE_W];
      end
    end
    if ((RDW_MODE == RDW_NEW) && rdw_hit_s) begin
      rd_word_s = merged_word_s;
    end else begin
      rd_word_s = old_word_s;
    end
  end

  // Output register next-state: read_data holds when no read is accepted.
  always_comb begin
    rd_valid_d = user_rd_s;
    if (user_rd_s) begin
      read_data_d = rd_word_s;
    end else begin
      read_data_d = read_data_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign busy      = busy_s;
  assign read_data = read_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_ram_dp_clear.sv
// ----------------------------------------------------------------------------
// tb_ram_dp_clear
// Two instances: A = 8-bit x 32, old-data RDW; B = 32-bit x 24 with 8-bit
// lanes, write-through RDW. Table-driven vectors plus hand-written sequences
// for sweep length, clear during sweep and reset mid-sweep.
// ----------------------------------------------------------------------------
module tb_ram_dp_clear;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A signals
  logic       a_clear, a_busy, a_wr_en, a_wr_mask, a_rd_en, a_rd_valid;
  logic [4:0] a_wr_address, a_rd_address;
  logic [7:0] a_wr_data, a_read_data;

  // Instance B signals
  logic        b_clear, b_busy, b_wr_en, b_rd_en, b_rd_valid;
  logic [4:0]  b_wr_address, b_rd_address;
  logic [3:0]  b_wr_mask;
  logic [31:0] b_wr_data, b_read_data;

  ram_dp_clear #(.SIZE(8), .DEPTH(32), .LANE_W(8), .RDW_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .busy(a_busy),
    .wr_en(a_wr_en), .wr_address(a_wr_address), .wr_data(a_wr_data),
    .wr_mask(a_wr_mask), .rd_en(a_rd_en), .rd_address(a_rd_address),
    .read_data(a_read_data), .rd_valid(a_rd_valid)
  );

  ram_dp_clear #(.SIZE(32), .DEPTH(24), .LANE_W(8), .RDW_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .busy(b_busy),
    .wr_en(b_wr_en), .wr_address(b_wr_address), .wr_data(b_wr_data),
    .wr_mask(b_wr_mask), .rd_en(b_rd_en), .rd_address(b_rd_address),
    .read_data(b_read_data), .rd_valid(b_rd_valid)
  );

  typedef struct {
    bit          dut;   // 0 = A, 1 = B
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  wm;
    bit          re;
    logic [4:0]  ra;
    bit          ev;    // expected rd_valid
    logic [31:0] ed;    // expected read_data
  } vec_t;

  vec_t vq[$];
  int   n_pass, n_total;
  int   ca, cb, cnt, bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit d, input bit we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [3:0] wm, input bit re,
                     input logic [4:0] ra, input bit ev, input logic [31:0] ed);
    vec_t v;
    v = '{d, we, wa, wd, wm, re, ra, ev, ed};
    vq.push_back(v);
  endtask

  task automatic idle_all();
    a_clear = 1'b0; a_wr_en = 1'b0; a_wr_address = 5'd0; a_wr_data = 8'h00;
    a_wr_mask = 1'b0; a_rd_en = 1'b0; a_rd_address = 5'd0;
    b_clear = 1'b0; b_wr_en = 1'b0; b_wr_address = 5'd0; b_wr_data = 32'h0;
    b_wr_mask = 4'h0; b_rd_en = 1'b0; b_rd_address = 5'd0;
  endtask

  // Counts cycles with busy high, starting at the current (negedge) sample.
  task automatic count_sweep(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int k = 0; k < 80; k++) begin
      if (!a_busy && !b_busy) break;
      if (a_busy) na++;
      if (b_busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic read_all_a(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a_rd_en = 1'b1;
      a_rd_address = 5'(i);
      @(posedge clk);
      #1;
      chk($sformatf("%s_addr%0d", tag, i), {23'd0, a_rd_valid, a_read_data}, 32'h100);
    end
    @(negedge clk);
    a_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    idle_all();

    // Reset values while rst_n is held low
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_a", {31'd0, a_busy}, 32'd1);
    chk("rst_valid_a", {31'd0, a_rd_valid}, 32'd0);
    chk("rst_data_a", {24'd0, a_read_data}, 32'd0);
    chk("rst_busy_b", {31'd0, b_busy}, 32'd1);
    chk("rst_data_b", b_read_data, 32'd0);

    // Sweep after reset release is exactly DEPTH cycles
    @(negedge clk);
    rst_n = 1'b1;
    count_sweep(ca, cb);
    chk("sweep_len_a", ca, 32'd32);
    chk("sweep_len_b", cb, 32'd24);
    read_all_a("init");

    // Directed vectors
    add(1'b1, 1'b1, 5'd5,  32'hAABBCCDD, 4'hF, 1'b0, 5'd0,  1'b0, 32'h0);
    add(1'b1, 1'b1, 5'd5,  32'h11223344, 4'h5, 1'b0, 5'd0,  1'b0, 32'h0);
    add(1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd5,  1'b1, 32'hAA22CC44);
    add(1'b1, 1'b1, 5'd5,  32'hFFFFFFFF, 4'h0, 1'b1, 5'd5,  1'b1, 32'hAA22CC44);
    add(1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd5,  1'b1, 32'hAA22CC44);
    add(1'b1, 1'b1, 5'd25, 32'h77,       4'hF, 1'b0, 5'd0,  1'b0, 32'hAA22CC44);
    add(1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd25, 1'b1, 32'h0);
    add(1'b1, 1'b1, 5'd23, 32'h12345678, 4'hF, 1'b1, 5'd23, 1'b1, 32'h12345678);
    add(1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd23, 1'b1, 32'h12345678);
    add(1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  1'b0, 32'h12345678);
    add(1'b1, 1'b1, 5'd25, 32'h77,       4'hF, 1'b1, 5'd25, 1'b1, 32'h0);
    add(1'b1, 1'b1, 5'd3,  32'h5A,       4'hF, 1'b0, 5'd0,  1'b0, 32'h0);
    add(1'b1, 1'b1, 5'd3,  32'hC3,       4'hF, 1'b1, 5'd3,  1'b1, 32'hC3);
    add(1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd3,  1'b1, 32'hC3);
    add(1'b1, 1'b1, 5'd3,  32'hAABBCCDD, 4'h2, 1'b1, 5'd3,  1'b1, 32'h0000CCC3);
    add(1'b1, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd3,  1'b1, 32'h0000CCC3);
    add(1'b0, 1'b1, 5'd3,  32'h5A,       4'h1, 1'b0, 5'd0,  1'b0, 32'h0);
    add(1'b0, 1'b1, 5'd3,  32'hC3,       4'h1, 1'b1, 5'd3,  1'b1, 32'h5A);
    add(1'b0, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd3,  1'b1, 32'hC3);
    add(1'b0, 1'b1, 5'd4,  32'h99,       4'h1, 1'b1, 5'd3,  1'b1, 32'hC3);
    add(1'b0, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd4,  1'b1, 32'h99);
    add(1'b0, 1'b1, 5'd31, 32'hE7,       4'h0, 1'b1, 5'd31, 1'b1, 32'h0);
    add(1'b0, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd31, 1'b1, 32'h0);
    add(1'b0, 1'b1, 5'd31, 32'hE7,       4'h1, 1'b1, 5'd0,  1'b1, 32'h0);
    add(1'b0, 1'b0, 5'd0,  32'h0,        4'h0, 1'b1, 5'd31, 1'b1, 32'hE7);

    foreach (vq[i]) begin
      @(negedge clk);
      idle_all();
      if (vq[i].dut) begin
        b_wr_en = vq[i].we; b_wr_address = vq[i].wa; b_wr_data = vq[i].wd;
        b_wr_mask = vq[i].wm; b_rd_en = vq[i].re; b_rd_address = vq[i].ra;
      end else begin
        a_wr_en = vq[i].we; a_wr_address = vq[i].wa; a_wr_data = vq[i].wd[7:0];
        a_wr_mask = vq[i].wm[0]; a_rd_en = vq[i].re; a_rd_address = vq[i].ra;
      end
      @(posedge clk);
      #1;
      if (vq[i].dut) begin
        chk($sformatf("vec%0d_valid", i), {31'd0, b_rd_valid}, {31'd0, vq[i].ev});
        chk($sformatf("vec%0d_data", i), b_read_data, vq[i].ed);
      end else begin
        chk($sformatf("vec%0d_valid", i), {31'd0, a_rd_valid}, {31'd0, vq[i].ev});
        chk($sformatf("vec%0d_data", i), {24'd0, a_read_data}, vq[i].ed);
      end
    end
    @(negedge clk);
    idle_all();

    // Fill A with 0xFF, then clear with a same-cycle write
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a_wr_en = 1'b1; a_wr_address = 5'(i); a_wr_data = 8'hFF; a_wr_mask = 1'b1;
    end
    @(negedge clk);
    a_wr_en = 1'b0; a_rd_en = 1'b1; a_rd_address = 5'd7;
    @(posedge clk);
    #1;
    chk("fill_read", {23'd0, a_rd_valid, a_read_data}, 32'h1FF);
    @(negedge clk);
    a_rd_en = 1'b0; a_clear = 1'b1;
    a_wr_en = 1'b1; a_wr_address = 5'd9; a_wr_data = 8'h11; a_wr_mask = 1'b1;
    @(negedge clk);
    a_clear = 1'b0; a_wr_address = 5'd2; a_wr_data = 8'hAB;
    a_rd_en = 1'b1; a_rd_address = 5'd7;
    cnt = 0; bad = 0;
    for (int k = 0; k < 80; k++) begin
      if (!a_busy) break;
      cnt++;
      if (a_rd_valid !== 1'b0 || a_read_data !== 8'hFF) bad++;
      a_clear = (cnt == 5);
      @(negedge clk);
    end
    idle_all();
    chk("clear_sweep_len", cnt, 32'd32);
    chk("busy_ignores_traffic", bad, 32'd0);
    read_all_a("after_clear");

    // Reset at sweep cycle 10 while B has a read in flight
    @(negedge clk);
    a_wr_en = 1'b1; a_wr_address = 5'd1; a_wr_data = 8'h5C; a_wr_mask = 1'b1;
    @(negedge clk);
    a_wr_en = 1'b0; a_rd_en = 1'b1; a_rd_address = 5'd1;
    @(posedge clk);
    #1;
    chk("pre_rst_read_a", {24'd0, a_read_data}, 32'h5C);
    @(negedge clk);
    a_rd_en = 1'b0; a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    repeat (9) @(negedge clk);
    b_rd_en = 1'b1; b_rd_address = 5'd3;
    @(negedge clk);
    chk("pre_rst_valid_b", {31'd0, b_rd_valid}, 32'd1);
    chk("pre_rst_data_b", b_read_data, 32'h0000CCC3);
    rst_n = 1'b0;
    b_rd_en = 1'b0;
    #1;
    chk("midrst_busy_a", {31'd0, a_busy}, 32'd1);
    chk("midrst_data_a", {24'd0, a_read_data}, 32'd0);
    chk("midrst_valid_b", {31'd0, b_rd_valid}, 32'd0);
    chk("midrst_data_b", b_read_data, 32'd0);
    chk("midrst_busy_b", {31'd0, b_busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    count_sweep(ca, cb);
    chk("resweep_len_a", ca, 32'd32);
    chk("resweep_len_b", cb, 32'd24);
    a_rd_en = 1'b1; a_rd_address = 5'd1;
    b_rd_en = 1'b1; b_rd_address = 5'd3;
    @(posedge clk);
    #1;
    chk("post_rst_read_a", {23'd0, a_rd_valid, a_read_data}, 32'h100);
    chk("post_rst_read_b", b_read_data, 32'd0);
    @(negedge clk);
    idle_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_dp_clear.md
Name: ram_dp_clear

Overview:
Parametrised simple-dual-port synchronous RAM. It has one write port and one read port, per-lane write masking, a selectable read-during-write policy, and a built-in zeroing sequencer.
- Sweeps the whole array to zero after reset, or on request.
- Sits beside game-state logic as scratch/board storage that must start from a known state.

Parameters:
SIZE, 8, bits per entry; must be a multiple of LANE_W
DEPTH, 32, number of entries; need not be a power of two
LANE_W, 8, bits per write-mask lane; LANES = SIZE/LANE_W
RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (write-through) data

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  pulse: start zeroing sweep
busy  output  1  high while sweep in progress
wr_en  input  1  write request
wr_address  input  $clog2(DEPTH)  write address
wr_data  input  SIZE  write data
wr_mask  input  LANES  per-lane write enable; bit i covers bits [i*LANE_W +: LANE_W]
rd_en  input  1  read request
rd_address  input  $clog2(DEPTH)  read address
read_data  output  SIZE  registered read data
rd_valid  output  1  read_data updated this cycle

Behaviour:
- Reset (rst_n low, asynchronous):
  - busy=1, read_data=0, rd_valid=0, sweep pointer=0, FSM=CLEAR.
  - The array itself is not reset; the sweep zeroes it.
- FSM states:
  - CLEAR:
    - Each cycle writes 0 to array[ptr]; ptr increments.
    - On the cycle ptr==DEPTH-1 is written, go to IDLE; busy falls on the next edge.
    - A sweep is exactly DEPTH cycles.
  - IDLE:
    - busy=0.
    - clear=1 -> CLEAR with ptr=0; busy=1 from the next edge.
- clear while in CLEAR is ignored; the sweep is not restarted.
- While busy:
  - wr_en and rd_en are ignored.
  - rd_valid=0.
  - read_data holds its last value.
- Write (IDLE, wr_en=1, wr_address<DEPTH):
  - Lanes with wr_mask[i]=1 take wr_data; other lanes keep their contents.
  - wr_mask=0 means no change.
- Read (IDLE, rd_en=1): 1-cycle latency.
  - read_data <= array[rd_address] and rd_valid=1 on the next edge.
  - rd_en=0 -> rd_valid=0 next cycle; read_data holds.
- Read-during-write, same cycle, same address, both enabled:
  - RDW_MODE=0: read_data = contents before the write.
  - RDW_MODE=1: read_data = merged word; masked lanes from wr_data, others old.
  - Different addresses: no interaction.
- Out-of-range address (>=DEPTH, non-power-of-two DEPTH only):
  - Write is dropped.
  - Read returns 0 with rd_valid=1.
- Reset mid-sweep or mid-read:
  - Outputs go to reset values immediately.
  - On rst_n release, the sweep restarts from ptr=0.
- clear and wr_en in the same IDLE cycle: the write completes, then the sweep zeroes it.
- Width rule: the pointer is $clog2(DEPTH) bits. It never exceeds DEPTH-1 and must not wrap into a partial second sweep.

Decomposition:
- Shared package (ram_pkg):
  - FSM state enum {IDLE, CLEAR}.
  - RDW_OLD=0 / RDW_NEW=1 constants.
  - lanes(SIZE, LANE_W) helper.
- Sub-module ram_clear_seq:
  - Owns the FSM and pointer.
  - Outputs busy, sweep_we, sweep_addr.
- The top muxes sweep versus user write onto the single array write port, and holds the lane-merge and RDW logic.

Test Plan:
1. Default params; release rst_n -> busy=1 for exactly 32 cycles, then 0. Read addresses 0..31 -> read_data=0x00, rd_valid=1 one cycle after each rd_en.
2. SIZE=32, LANE_W=8: write 0xAABBCCDD mask 4'b1111 to addr 5, then 0x11223344 mask 4'b0101 -> read addr 5 = 0xAA22CC44. Then mask 4'b0000 with any data -> still 0xAA22CC44.
3. Addr 3 holds 0x5A; same cycle write 0xC3 (full mask) and read addr 3:
   - RDW_MODE=0 -> read_data 0x5A.
   - RDW_MODE=1 -> 0xC3.
   - Following read returns 0xC3 in both modes.
4. Fill all entries with 0xFF, pulse clear -> busy=1 for 32 cycles. wr_en/rd_en during sweep are ignored with rd_valid=0. Afterwards all reads = 0x00. A second clear pulse mid-sweep does not extend busy beyond 32 cycles.
5. Assert rst_n low at sweep cycle 10 -> busy=1, rd_valid=0, read_data=0 immediately. On release, busy stays high for a full 32 cycles.
6. DEPTH=24: after sweep, write 0x77 to addr 25 -> dropped. Read addr 25 -> 0x00 with rd_valid=1. Addr 23 read/write works normally.
